// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder: register offsets
// inside the MMIO window, control/status bit positions, reset constants and
// a byte-lane merge helper used by every register that honours lane enables.
package dmem_mmio_responder_pkg;

    // Byte offsets of the registers inside the 32-byte MMIO window.
    localparam logic [4:0] OFF_LED    = 5'h00;
    localparam logic [4:0] OFF_TCTRL  = 5'h04;
    localparam logic [4:0] OFF_TCOUNT = 5'h08;
    localparam logic [4:0] OFF_TCMP   = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    // TCTRL bit positions.
    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_IRQ_EN = 1;

    // STATUS bit positions (both are write-one-to-clear).
    localparam int STATUS_IRQ = 0;
    localparam int STATUS_ERR = 1;

    // Compare value after reset: the timer wraps naturally at 32 bits.
    localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

    // Which part of the address space the current access falls into.
    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

    // Replace the bytes of old_val selected by lanes with those of new_val.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port between the single-cycle core and its memory responder.
// The core drives address, store data, store strobe and byte lanes; the
// responder returns load data combinationally in the same cycle.
interface dmem_mmio_responder_if;

    logic        memwrite;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output wea,
        output addr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  wea,
        input  addr,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/mmio_timer.sv
// Compare/wrap timer with its control, count, compare and interrupt-flag
// registers. Write strobes arrive already decoded; lanes carry the effective
// byte enables (already gated by the store strobe).
module mmio_timer
    import dmem_mmio_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_tctrl,
    input  logic        wr_tcount,
    input  logic        wr_tcmp,
    input  logic        wr_status,
    input  logic [3:0]  lanes,
    input  logic [31:0] wdata,
    output logic [31:0] tctrl,
    output logic [31:0] tcount,
    output logic [31:0] tcmp,
    output logic        status_irq,
    output logic        irq
);

    logic        en_q;
    logic        irq_en_q;
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        irq_q;

    logic        hit;
    logic        clear_irq;
    logic [31:0] count_next;
    logic [31:0] cmp_next;
    logic        irq_next;

    // Next-state: a software count write wins over increment/wrap, and a hardware hit wins over a W1C clear.
    always_comb begin
        hit        = en_q && (count_q == cmp_q);
        clear_irq  = wr_status && lanes[0] && wdata[STATUS_IRQ];
        count_next = count_q;
        if (wr_tcount && (lanes != 4'b0000)) begin
            count_next = merge_lanes(count_q, wdata, lanes);
        end else if (hit) begin
            count_next = '0;
        end else if (en_q) begin
            count_next = count_q + 32'd1;
        end
        cmp_next = cmp_q;
        if (wr_tcmp) begin
            cmp_next = merge_lanes(cmp_q, wdata, lanes);
        end
        irq_next = hit | (irq_q & ~clear_irq);
    end

    // Timer state registers; reset aborts any count in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            count_q  <= '0;
            cmp_q    <= TCMP_RST;
            irq_q    <= 1'b0;
        end else begin
            if (wr_tctrl && lanes[0]) begin
                en_q     <= wdata[TCTRL_EN];
                irq_en_q <= wdata[TCTRL_IRQ_EN];
            end
            count_q <= count_next;
            cmp_q   <= cmp_next;
            irq_q   <= irq_next;
        end
    end

    // Register views for the read mux; unimplemented TCTRL bits read as zero.
    always_comb begin
        tctrl               = '0;
        tctrl[TCTRL_EN]     = en_q;
        tctrl[TCTRL_IRQ_EN] = irq_en_q;
        tcount              = count_q;
        tcmp                = cmp_q;
        status_irq          = irq_q;
        irq                 = irq_q & irq_en_q;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: a word-addressed RAM with
// byte-lane stores, an LED register, an error flag for stray stores and a
// compare/wrap timer, all behind a zero-wait-state combinational read path.
// MMIO_BASE is expected to be aligned to the 32-byte window size.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0000_8000,
    parameter int          LED_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_mmio_responder_if.slave  bus,
    output logic [LED_W-1:0]      led,
    output logic                  irq
);

    logic [31:0]       ram [2**RAM_AW];

    logic              ram_hit;
    logic              mmio_hit;
    region_e           region;
    logic [RAM_AW-1:0] word_idx;
    logic [4:0]        reg_off;
    logic [3:0]        lanes;

    logic              wr_mmio;
    logic              wr_led;
    logic              wr_tctrl;
    logic              wr_tcount;
    logic              wr_tcmp;
    logic              wr_status;

    logic [LED_W-1:0]  led_q;
    logic [31:0]       led_next;
    logic              err_q;
    logic              err_set;
    logic              err_clr;

    logic [31:0]       tctrl;
    logic [31:0]       tcount;
    logic [31:0]       tcmp;
    logic              status_irq;
    logic [31:0]       rdata;

    logic              unused_bits;

    assign ram_hit  = (bus.addr >> (RAM_AW + 2)) == 32'd0;
    assign mmio_hit = bus.addr[31:5] == MMIO_BASE[31:5];
    assign word_idx = bus.addr[RAM_AW+1:2];
    assign reg_off  = {bus.addr[4:2], 2'b00};
    assign lanes    = bus.memwrite ? bus.wea : 4'b0000;

    // Address decode into RAM, MMIO window or unmapped space.
    always_comb begin
        if (ram_hit) begin
            region = REGION_RAM;
        end else if (mmio_hit) begin
            region = REGION_MMIO;
        end else begin
            region = REGION_NONE;
        end
    end

    assign wr_mmio   = (region == REGION_MMIO) && bus.memwrite;
    assign wr_led    = wr_mmio && (reg_off == OFF_LED);
    assign wr_tctrl  = wr_mmio && (reg_off == OFF_TCTRL);
    assign wr_tcount = wr_mmio && (reg_off == OFF_TCOUNT);
    assign wr_tcmp   = wr_mmio && (reg_off == OFF_TCMP);
    assign wr_status = wr_mmio && (reg_off == OFF_STATUS);

    assign err_set = (region == REGION_NONE) && (lanes != 4'b0000);
    assign err_clr = wr_status && lanes[0] && bus.writedata[STATUS_ERR];

    // RAM byte-lane stores; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (region == REGION_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    ram[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    // LED value after a lane-merged store, widened to a full bus word.
    always_comb begin
        led_next = merge_lanes(32'(led_q), bus.writedata, lanes);
    end

    // LED register; only the implemented low bits are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= led_next[LED_W-1:0];
        end
    end

    // Sticky error flag for stores to unmapped space; a new error beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set | (err_q & ~err_clr);
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_tctrl   (wr_tctrl),
        .wr_tcount  (wr_tcount),
        .wr_tcmp    (wr_tcmp),
        .wr_status  (wr_status),
        .lanes      (lanes),
        .wdata      (bus.writedata),
        .tctrl      (tctrl),
        .tcount     (tcount),
        .tcmp       (tcmp),
        .status_irq (status_irq),
        .irq        (irq)
    );

    // Combinational load path; unmapped space and reserved offsets read as zero.
    always_comb begin
        rdata = '0;
        case (region)
            REGION_RAM: begin
                rdata = ram[word_idx];
            end
            REGION_MMIO: begin
                case (reg_off)
                    OFF_LED:    rdata = 32'(led_q);
                    OFF_TCTRL:  rdata = tctrl;
                    OFF_TCOUNT: rdata = tcount;
                    OFF_TCMP:   rdata = tcmp;
                    OFF_STATUS: begin
                        rdata[STATUS_IRQ] = status_irq;
                        rdata[STATUS_ERR] = err_q;
                    end
                    default:    rdata = '0;
                endcase
            end
            default: begin
                rdata = '0;
            end
        endcase
    end

    assign bus.readdata = rdata;
    assign led          = led_q;

    // Byte offset bits and the LED bits above LED_W are intentionally dropped.
    assign unused_bits = &{1'b0, bus.addr[1:0], led_next};

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for the data-memory / MMIO responder: a table of directed vectors,
// hand-written timer and reset sequences, then randomized traffic compared
// against a behavioural model of the memory map kept in this file.
module tb_dmem_mmio_responder;

    localparam int          RAM_AW    = 10;
    localparam logic [31:0] MMIO_BASE = 32'h0000_8000;
    localparam int          LED_W     = 16;
    localparam logic [31:0] RAM_BYTES = 32'(4 * (2**RAM_AW));
    localparam logic [31:0] LED_MASK  = (32'h1 << LED_W) - 32'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic [LED_W-1:0] led;
    logic             irq;

    int errors = 0;
    int checks = 0;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(
        .RAM_AW    (RAM_AW),
        .MMIO_BASE (MMIO_BASE),
        .LED_W     (LED_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led),
        .irq (irq)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural model of the memory map.
    logic [31:0] m_ram [int];
    logic [31:0] m_led;
    logic [31:0] m_tcount;
    logic [31:0] m_tcmp;
    logic        m_en;
    logic        m_irq_en;
    logic        m_irq;
    logic        m_err;

    typedef struct {
        logic        mw;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic mw, input logic [3:0] wea, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                                   input string name);
        vec_t v;
        v.mw = mw; v.wea = wea; v.addr = addr; v.wdata = wdata;
        v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] laneMerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] l);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (l[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // 0 = RAM, 1 = MMIO window, 2 = unmapped
    function automatic int regionOf(input logic [31:0] a);
        if (a < RAM_BYTES) return 0;
        if (a >= MMIO_BASE && a < MMIO_BASE + 32'h20) return 1;
        return 2;
    endfunction

    function automatic void modelReset();
        m_led = 0; m_tcount = 0; m_tcmp = 32'hFFFF_FFFF;
        m_en = 0; m_irq_en = 0; m_irq = 0; m_err = 0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        int          r;
        int          w;
        logic [31:0] off;
        r   = regionOf(a);
        w   = int'(a >> 2);
        off = (a - MMIO_BASE) & ~32'h3;
        if (r == 0) return m_ram.exists(w) ? m_ram[w] : 32'hx;
        if (r == 2) return 32'h0;
        case (off)
            32'h00:  return m_led;
            32'h04:  return {30'h0, m_irq_en, m_en};
            32'h08:  return m_tcount;
            32'h0C:  return m_tcmp;
            32'h10:  return {30'h0, m_err, m_irq};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs held during that cycle.
    function automatic void modelCommit(input logic mw, input logic [3:0] we,
                                        input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  l;
        int          r;
        int          w;
        logic [31:0] off;
        logic        wrap;
        logic        stray;
        logic [31:0] cnt;
        logic        nirq;
        logic        nerr;
        l     = mw ? we : 4'b0;
        r     = regionOf(a);
        w     = int'(a >> 2);
        off   = (a - MMIO_BASE) & ~32'h3;
        wrap  = m_en && (m_tcount == m_tcmp);
        stray = (r == 2) && (l != 0);
        cnt   = !m_en ? m_tcount : (wrap ? 32'h0 : m_tcount + 32'h1);
        nirq  = m_irq | wrap;
        nerr  = m_err | stray;
        if (r == 0 && l != 0) m_ram[w] = laneMerge(m_ram.exists(w) ? m_ram[w] : 32'h0, d, l);
        if (r == 1 && l != 0) begin
            case (off)
                32'h00: m_led = laneMerge(m_led, d, l) & LED_MASK;
                32'h04: if (l[0]) begin m_en = d[0]; m_irq_en = d[1]; end
                32'h08: cnt = laneMerge(m_tcount, d, l);
                32'h0C: m_tcmp = laneMerge(m_tcmp, d, l);
                32'h10: if (l[0]) begin
                    if (d[0] && !wrap) nirq = 1'b0;
                    if (d[1] && !stray) nerr = 1'b0;
                end
                default: ;
            endcase
        end
        m_tcount = cnt;
        m_irq    = nirq;
        m_err    = nerr;
    endfunction

    // Drive one cycle's inputs at the falling edge and let the read path settle.
    task automatic applyStimulus(input logic mw, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.memwrite  = mw;
        bus.wea       = we;
        bus.addr      = a;
        bus.writedata = d;
        #1;
    endtask

    // Commit the current inputs to the model and let the DUT take the rising edge.
    task automatic stepCycle();
        modelCommit(bus.memwrite, bus.wea, bus.addr, bus.writedata);
        @(posedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    initial begin
        logic [31:0] cnt_exp [5];
        logic        irq_exp [5];
        cnt_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        irq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        bus.memwrite = 0; bus.wea = 0; bus.addr = 0; bus.writedata = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("led_in_rst", 32'(led), 32'h0);
        checkOutput("irq_in_rst", 32'(irq), 32'h0);
        #2 rst = 1'b0;
        $display("[TB] reset released, starting directed table");

        addVec(0, 4'h0, MMIO_BASE + 32'h0C, 32'h0, 1, 32'hFFFF_FFFF, "tcmp_rst");
        addVec(0, 4'h0, MMIO_BASE + 32'h10, 32'h0, 1, 32'h0, "status_rst");
        addVec(0, 4'h0, MMIO_BASE + 32'h08, 32'h0, 1, 32'h0, "tcount_rst");
        addVec(1, 4'hF, 32'h10, 32'h1122_3344, 0, 32'h0, "");
        addVec(0, 4'h0, 32'h10, 32'h0, 1, 32'h1122_3344, "full_store");
        addVec(1, 4'h5, 32'h10, 32'hAABB_CCDD, 0, 32'h0, "");
        addVec(0, 4'h0, 32'h10, 32'h0, 1, 32'h11BB_33DD, "lane_store");
        addVec(0, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, "");
        addVec(0, 4'h0, 32'h10, 32'h0, 1, 32'h11BB_33DD, "no_memwrite");
        addVec(1, 4'h0, 32'h10, 32'hCAFE_F00D, 0, 32'h0, "");
        addVec(0, 4'h0, 32'h10, 32'h0, 1, 32'h11BB_33DD, "wea_zero");
        addVec(1, 4'hF, RAM_BYTES - 32'h4, 32'hCAFE_BABE, 0, 32'h0, "");
        addVec(1, 4'hF, 32'h0, 32'h0BAD_F00D, 0, 32'h0, "");
        addVec(1, 4'hF, 32'h14, 32'h1357_9BDF, 0, 32'h0, "");
        addVec(0, 4'h0, RAM_BYTES - 32'h4, 32'h0, 1, 32'hCAFE_BABE, "last_word");
        addVec(0, 4'h0, 32'h0, 32'h0, 1, 32'h0BAD_F00D, "word0");
        addVec(0, 4'h0, RAM_BYTES - 32'h1, 32'h0, 1, 32'hCAFE_BABE, "alias_last");
        addVec(0, 4'h0, 32'h13, 32'h0, 1, 32'h11BB_33DD, "alias_low");
        addVec(0, 4'h0, RAM_BYTES, 32'h0, 1, 32'h0, "past_ram");
        addVec(1, 4'hF, 32'h0001_0000, 32'h1234_5678, 0, 32'h0, "");
        addVec(0, 4'h0, 32'h0001_0000, 32'h0, 1, 32'h0, "unmapped_rd");
        addVec(0, 4'h0, MMIO_BASE + 32'h10, 32'h0, 1, 32'h2, "err_set");
        addVec(0, 4'h0, 32'h0, 32'h0, 1, 32'h0BAD_F00D, "ram_untouched");
        addVec(0, 4'h0, MMIO_BASE + 32'h14, 32'h0, 1, 32'h0, "reserved_14");
        addVec(0, 4'h0, MMIO_BASE + 32'h1C, 32'h0, 1, 32'h0, "reserved_1c");
        addVec(1, 4'h1, MMIO_BASE + 32'h10, 32'h2, 0, 32'h0, "");
        addVec(0, 4'h0, MMIO_BASE + 32'h10, 32'h0, 1, 32'h0, "err_w1c");
        addVec(1, 4'hF, MMIO_BASE, 32'h1234_ABCD, 0, 32'h0, "");
        addVec(0, 4'h0, MMIO_BASE, 32'h0, 1, 32'h0000_ABCD, "led_rd");
        addVec(1, 4'h2, MMIO_BASE, 32'h0000_5500, 0, 32'h0, "");
        addVec(0, 4'h0, MMIO_BASE, 32'h0, 1, 32'h0000_55CD, "led_lane");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].mw, vecs[i].wea, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) checkOutput(vecs[i].name, bus.readdata, vecs[i].exp);
            stepCycle();
        end
        applyStimulus(0, 4'h0, 32'h0, 32'h0);
        checkOutput("led_port", 32'(led), 32'h0000_55CD);
        stepCycle();

        $display("[TB] timer sequence");
        applyStimulus(1, 4'hF, MMIO_BASE + 32'h0C, 32'd3);
        stepCycle();
        applyStimulus(1, 4'hF, MMIO_BASE + 32'h04, 32'd3);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 4'h0, MMIO_BASE + 32'h08, 32'h0);
            checkOutput("timer_count", bus.readdata, cnt_exp[i]);
            checkOutput("timer_irq", 32'(irq), 32'(irq_exp[i]));
            stepCycle();
        end
        applyStimulus(1, 4'h1, MMIO_BASE + 32'h10, 32'h1);
        checkOutput("irq_before_w1c", 32'(irq), 32'h1);
        stepCycle();
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h10, 32'h0);
        checkOutput("status_after_w1c", bus.readdata, 32'h0);
        checkOutput("irq_after_w1c", 32'(irq), 32'h0);
        stepCycle();
        applyStimulus(1, 4'h1, MMIO_BASE + 32'h10, 32'h1);
        stepCycle();
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h10, 32'h0);
        checkOutput("w1c_collision", bus.readdata, 32'h1);
        checkOutput("irq_collision", 32'(irq), 32'h1);
        stepCycle();
        applyStimulus(1, 4'h1, MMIO_BASE + 32'h10, 32'h1);
        stepCycle();
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h08, 32'h0);
        checkOutput("count_before_wrap", bus.readdata, 32'd2);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        stepCycle();
        applyStimulus(1, 4'hF, MMIO_BASE + 32'h08, 32'h100);
        stepCycle();
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h08, 32'h0);
        checkOutput("tcount_sw_wins", bus.readdata, 32'h100);
        checkOutput("irq_on_sw_wrap", 32'(irq), 32'h1);
        stepCycle();

        $display("[TB] mid-run reset");
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h0C, 32'h0);
        checkOutput("tcmp_before_rst", bus.readdata, 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("led_async_rst", 32'(led), 32'h0);
        checkOutput("irq_async_rst", 32'(irq), 32'h0);
        checkOutput("tcmp_async_rst", bus.readdata, 32'hFFFF_FFFF);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        bus.addr = MMIO_BASE + 32'h10;
        #1 checkOutput("status_in_rst", bus.readdata, 32'h0);
        bus.addr = RAM_BYTES - 32'h4;
        #1 checkOutput("ram_kept", bus.readdata, 32'hCAFE_BABE);
        rst = 1'b0;
        stepCycle();
        applyStimulus(0, 4'h0, MMIO_BASE + 32'h08, 32'h0);
        checkOutput("tcount_after_rst", bus.readdata, 32'h0);
        stepCycle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            int          kind;
            int          pick;
            logic [31:0] a;
            logic [31:0] d;
            logic        mw;
            logic [3:0]  we;
            logic [31:0] ram_words [4];
            logic [31:0] stray_addrs [4];
            ram_words   = '{32'd0, 32'd4, 32'd5, 32'(2**RAM_AW - 1)};
            stray_addrs = '{RAM_BYTES, 32'h0001_0000, MMIO_BASE - 32'h4, MMIO_BASE + 32'h20};
            kind = $urandom_range(0, 9);
            pick = $urandom_range(0, 3);
            if (kind < 4) a = ram_words[pick] * 4 + 32'($urandom_range(0, 3));
            else if (kind < 8) a = MMIO_BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            else if (kind == 8) a = stray_addrs[pick];
            else a = $urandom | 32'h8000_0000;
            mw = 1'($urandom_range(0, 1));
            we = 4'($urandom_range(0, 15));
            d  = $urandom;
            if (regionOf(a) == 1 && (((a - MMIO_BASE) & ~32'h3) inside {32'h08, 32'h0C}))
                d = 32'($urandom_range(0, 12));
            applyStimulus(mw, we, a, d);
            checkOutput("rnd_readdata", bus.readdata, modelRead(a));
            checkOutput("rnd_led", 32'(led), m_led);
            checkOutput("rnd_irq", 32'(irq), 32'(m_irq & m_irq_en));
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
